demux1to8_32b_reg: RTL and testbench
====================================

// Module: demux1to8_32b_reg
// PURPOSE
//   Registered 1-to-8 distributor of 32-bit words; the write-side counterpart of the 8-to-1 selectors.
//   A producer (ALU/memory datapath) presents a word plus a 3-bit destination select.
//   The block latches the word into one of 8 holding slots; each consumer drains its own slot via valid/ack.
//   Slots provide per-destination buffering with backpressure, so a stalled consumer never corrupts another.
// PARAMETERS
//   DATA_W   32   width of each word and each slot
//   SEL_W    3    select width; slot count N = 2**SEL_W (8 at default)
//   CNT_W    8    width of accepted-word counter (wraps)
// PORTS
//   clk        in   1             rising-edge clock, the only clock
//   reset      in   1             asynchronous, active-high; clears all state immediately
//   in_data    in   DATA_W        word to distribute
//   in_sel     in   SEL_W         destination slot index
//   in_valid   in   1             producer offers in_data/in_sel this cycle
//   in_ready   out  1             block accepts this cycle (combinational)
//   out_data   out  N*DATA_W      slot i at [i*DATA_W +: DATA_W]
//   out_valid  out  N             slot i holds an unconsumed word
//   out_ack    in   N             consumer i takes slot i this cycle
//   acc_count  out  CNT_W         number of accepted words, modulo 2**CNT_W
// BEHAVIOUR
//   Reset (async assert, sync deassert by clk): out_data=0, out_valid=0, acc_count=0.
//   in_ready = ~out_valid[in_sel] | out_ack[in_sel]  (full slot accepts only if drained same cycle).
//   Accept = in_valid & in_ready. On accept at edge: slot[in_sel] <= in_data, out_valid[in_sel] <= 1,
//     acc_count <= acc_count+1 (wraps 2**CNT_W-1 -> 0). Latency: word visible on out_data 1 cycle after accept.
//   Ack i with out_valid[i]=1 and no accept to i: out_valid[i] <= 0; out_data slot i retains last value.
//   Ack i with out_valid[i]=0: ignored, no state change.
//   Simultaneous ack i and accept to i: new word loaded, out_valid[i] stays 1 (no bubble).
//   Acks on several slots in one cycle are all honoured independently; at most one accept per cycle.
//   in_valid=0: in_ready still driven from in_sel (no X), no state change from input side.
//   Producer rule: in_data/in_sel held stable while in_valid=1 & in_ready=0; block does not rely on it.
//   Reset mid-operation: all slots emptied, pending words lost, counter cleared; in_ready then 1.
//   No combinational path from in_valid to in_ready; path out_ack -> in_ready exists by design.
// TESTING
//   T1 reset: assert reset mid-clock -> out_valid=0x00, out_data=0, acc_count=0 without waiting for clk.
//   T2 single write: in_sel=5, in_data=0xDEADBEEF, in_valid 1 cycle -> next cycle out_valid=0x20,
//      slot5=0xDEADBEEF, acc_count=1; other slots 0.
//   T3 backpressure: slot 2 full, no ack, offer sel=2 data=0x11 -> in_ready=0 for 3 cycles, slot2 unchanged;
//      then out_ack[2]=1 same cycle -> accepted, slot2=0x11, out_valid[2] stays 1.
//   T4 ack on empty slot 7 and multi-ack of slots 0,3 in one cycle -> slot7 unaffected, out_valid[0],[3] clear.
//   T5 wrap: 256 accepts round-robin sel 0..7 with immediate acks -> acc_count returns to 0x00, no drops.
//   T6 random: 10k cycles random in_valid/in_sel/out_ack vs scoreboard queue per slot -> zero mismatches.

Source files
------------

// File: rtl/demux1to8_32b_reg.sv
// Registered 1-to-N word distributor: one producer port, N buffered consumer slots,
// each drained independently through its own valid/ack handshake.
module demux1to8_32b_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 3,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned N     = 2 ** SEL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [SEL_W-1:0]    in_sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N*DATA_W-1:0] out_data,
    output logic [N-1:0]        out_valid,
    input  logic [N-1:0]        out_ack,
    output logic [CNT_W-1:0]    acc_count
);

    logic [DATA_W-1:0] slot_q [N];
    logic [DATA_W-1:0] slot_d [N];
    logic [N-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    // A full slot can still take a word when its consumer drains it in the same cycle.
    assign in_ready = ~valid_q[in_sel] | out_ack[in_sel];
    assign accept   = in_valid & in_ready;

    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q & ~out_ack;
        cnt_d   = cnt_q;
        if (accept) begin
            slot_d[in_sel]  = in_data;
            valid_d[in_sel] = 1'b1;
            cnt_d           = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            slot_q  <= slot_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_out
        assign out_data[i*DATA_W +: DATA_W] = slot_q[i];
    end

    assign out_valid = valid_q;
    assign acc_count = cnt_q;

endmodule

// File: tb/tb_demux1to8_32b_reg.sv
// Scoreboard bench for demux1to8_32b_reg: directed scenarios followed by random traffic,
// checked against per-slot expected-word queues.
module tb_demux1to8_32b_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ack;
    logic [7:0]   acc_count;

    demux1to8_32b_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .acc_count (acc_count)
    );

    always #5 clk = ~clk;

    // Reference model: words each slot currently holds, last word ever written, accept count.
    logic [31:0] exp_q [8][$];
    logic [31:0] last  [8];
    logic [7:0]  model_cnt;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            exp_q[i].delete();
            last[i] = '0;
        end
        model_cnt = '0;
    endtask

    // Drive one cycle of inputs (called at posedge+1) and record what the edge should accept.
    task automatic step(input logic v, input logic [2:0] s, input logic [31:0] d,
                        input logic [7:0] a);
        logic take;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
        take = v && (exp_q[s].size() == 0 || a[s]);
        @(posedge clk);
        #1;
        if (take) begin
            exp_q[s].push_back(d);
            last[s]   = d;
            model_cnt = model_cnt + 8'd1;
        end
    endtask

    // Monitor: mid-cycle, compare all outputs to the model and retire acknowledged words.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", 64'(in_ready), 64'(exp_q[in_sel].size() == 0 || out_ack[in_sel]));
            chk("acc_count", 64'(acc_count), 64'(model_cnt));
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]),
                    64'(exp_q[i].size() != 0));
                chk($sformatf("slot%0d_hold", i), 64'(out_data[i*32 +: 32]), 64'(last[i]));
                if (out_ack[i] && exp_q[i].size() != 0) begin
                    chk($sformatf("slot%0d_pop", i), 64'(out_data[i*32 +: 32]),
                        64'(exp_q[i].pop_front()));
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = '0;
        in_data  = '0;
        out_ack  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // T2: single write to slot 5
        step(1'b1, 3'd5, 32'hDEADBEEF, 8'h00);
        step(1'b0, 3'd0, 32'h0, 8'h00);
        chk("t2_valid", 64'(out_valid), 64'h20);
        chk("t2_slot5", 64'(out_data[5*32 +: 32]), 64'hDEADBEEF);
        chk("t2_count", 64'(acc_count), 64'd1);
        chk("t2_others", 64'(|(out_data & ~(256'hFFFFFFFF << 160))), 64'd0);

        // T3: backpressure on full slot 2, then accept on same-cycle ack
        step(1'b1, 3'd2, 32'h22, 8'h00);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h11; out_ack = 8'h00;
            #1 chk("t3_stall_ready", 64'(in_ready), 64'd0);
            step(1'b1, 3'd2, 32'h11, 8'h00);
            chk("t3_stall_slot2", 64'(out_data[2*32 +: 32]), 64'h22);
        end
        in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h11; out_ack = 8'h04;
        #1 chk("t3_ack_ready", 64'(in_ready), 64'd1);
        step(1'b1, 3'd2, 32'h11, 8'h04);
        chk("t3_slot2", 64'(out_data[2*32 +: 32]), 64'h11);
        chk("t3_valid2", 64'(out_valid[2]), 64'd1);

        // T4: ack on empty slot 7 alongside a multi-ack of slots 0 and 3
        step(1'b1, 3'd0, 32'hA0A0A0A0, 8'h00);
        step(1'b1, 3'd3, 32'hB3B3B3B3, 8'h00);
        step(1'b0, 3'd0, 32'h0, 8'b1000_1001);
        step(1'b0, 3'd0, 32'h0, 8'h00);
        chk("t4_valid", 64'(out_valid), 64'h24);
        chk("t4_slot7", 64'(out_data[7*32 +: 32]), 64'h0);
        chk("t4_slot0_kept", 64'(out_data[0*32 +: 32]), 64'hA0A0A0A0);

        // T1: asynchronous reset mid-cycle clears everything before the next edge
        #3 reset = 1'b1;
        model_clear();
        #1;
        chk("t1_valid", 64'(out_valid), 64'h0);
        chk("t1_data", 64'(|out_data), 64'h0);
        chk("t1_count", 64'(acc_count), 64'h0);
        chk("t1_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1 reset = 1'b0;

        // T5: 256 round-robin accepts with all slots acked wrap the counter
        for (int k = 0; k < 256; k++) begin
            step(1'b1, 3'(k % 8), $urandom, 8'hFF);
        end
        out_ack = 8'h00; in_valid = 1'b0;
        #1;
        chk("t5_count", 64'(acc_count), 64'h0);
        chk("t5_valid", 64'(out_valid), 64'h80);

        // T6: random traffic
        for (int k = 0; k < 10000; k++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                 8'($urandom) & 8'($urandom));
        end
        step(1'b0, 3'd0, 32'h0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
